// File: rtl/nv_ram_rwsp_param.sv
// Parametrised single-clock RAM with one read and one write port, optional output
// register, read-during-write forwarding, hardware zero-init and sticky access-error flag.
module nv_ram_rwsp_param #(
    parameter int DW            = 129,
    parameter int DEPTH         = 128,
    parameter int AW            = 7,
    parameter int OUT_REG       = 1,
    parameter int FORWARD       = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic [AW-1:0] ra,
    input  logic          re,
    input  logic          ore,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    output logic          init_done,
    output logic          acc_err,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_READY = 1'b1;
    localparam logic [0:0]    ST_RST   = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C   = AW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic [AW-1:0] ra_q;
    logic          s1_vld_q;
    logic          acc_err_q;
    logic [DW-1:0] mem [DEPTH];

    logic          ready;
    logic          wa_ok, ra_ok, rd_ok;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          err_set;
    logic [DW-1:0] rd;

    // Power-bus pins exist for the RAM wrapper only; ore is dead when OUT_REG=0.
    logic unused_ok;
    assign unused_ok = ^{pwrbus_ram_pd, ore};

    assign ready = (state_q == ST_READY);
    assign wa_ok = ({1'b0, wa} < DEPTH_C);
    assign ra_ok = ({1'b0, ra} < DEPTH_C);
    assign rd_ok = ({1'b0, ra_q} < DEPTH_C);

    // The init sequencer owns the write port until the array is cleared.
    assign mem_we  = ready ? (we & wa_ok) : 1'b1;
    assign mem_wa  = ready ? wa : init_ptr_q;
    assign mem_wd  = ready ? di : '0;
    assign err_set = ready ? ((we & ~wa_ok) | (re & ~ra_ok)) : (we | re);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + AW'(1);
            if (init_ptr_q == LAST_C) begin
                state_d = ST_READY;
            end
        end
    end

    // NOTE: the array has no reset branch; clearing it is the init sequencer's job.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_RST;
            init_ptr_q <= '0;
            ra_q       <= '0;
            s1_vld_q   <= 1'b0;
            acc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            s1_vld_q   <= ready & re;
            if (ready && re) begin
                ra_q <= ra;
            end
            if (err_set) begin
                acc_err_q <= 1'b1;
            end
        end
    end

    // NOTE: rd gets a default before any branch so no latch is inferred.
    always_comb begin
        rd = '0;
        if (rd_ok) begin
            rd = mem[ra_q];
            if ((FORWARD != 0) && ready && we && wa_ok && (wa == ra_q)) begin
                rd = di;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] dout_q;
            logic          dout_vld_q;

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else if (ore) begin
                    dout_q     <= rd;
                    dout_vld_q <= s1_vld_q;
                end
            end

            assign dout     = dout_q;
            assign dout_vld = dout_vld_q;
        end else begin : g_comb
            assign dout     = rd;
            assign dout_vld = s1_vld_q;
        end
    endgenerate

    assign init_done = ready;
    assign acc_err   = acc_err_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param: default instance (A) and a DEPTH=100, unregistered,
// non-forwarding instance (B) share stimulus and are scored against array models.
module tb_nv_ram_rwsp_param;

    localparam int DW      = 129;
    localparam int DEPTH_A = 128;
    localparam int DEPTH_B = 100;

    logic          clk = 1'b0;
    logic          reset_, re, ore, we;
    logic [6:0]    ra, wa;
    logic [DW-1:0] di;
    logic [31:0]   pwr;

    logic [DW-1:0] dout_a, dout_b;
    logic          dout_vld_a, dout_vld_b, init_done_a, init_done_b, acc_err_a, acc_err_b;

    int errors = 0;
    int checks = 0;

    // Reference: word arrays, sticky error flags and remaining init cycles.
    logic [DW-1:0] mem_a [DEPTH_A];
    logic [DW-1:0] mem_b [DEPTH_B];
    bit            err_a, err_b;
    int            init_a, init_b;

    always #5 clk = ~clk;

    nv_ram_rwsp_param dut_a (
        .clk(clk), .reset_(reset_), .ra(ra), .re(re), .ore(ore),
        .dout(dout_a), .dout_vld(dout_vld_a), .wa(wa), .we(we), .di(di),
        .init_done(init_done_a), .acc_err(acc_err_a), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsp_param #(
        .DW(DW), .DEPTH(DEPTH_B), .AW(7), .OUT_REG(0), .FORWARD(0), .INIT_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset_(reset_), .ra(ra), .re(re), .ore(ore),
        .dout(dout_b), .dout_vld(dout_vld_b), .wa(wa), .we(we), .di(di),
        .init_done(init_done_b), .acc_err(acc_err_b), .pwrbus_ram_pd(pwr)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Apply the effect of the clock edge that just happened with the held inputs.
    task automatic commit();
        if (!reset_) begin
            init_a = DEPTH_A; init_b = DEPTH_B; err_a = 1'b0; err_b = 1'b0;
        end else begin
            if (init_a > 0) begin
                if (re || we) err_a = 1'b1;
                init_a--;
                if (init_a == 0) foreach (mem_a[i]) mem_a[i] = '0;
            end else begin
                if (we && wa < DEPTH_A) mem_a[wa] = di;
                else if (we) err_a = 1'b1;
                if (re && ra >= DEPTH_A) err_a = 1'b1;
            end
            if (init_b > 0) begin
                if (re || we) err_b = 1'b1;
                init_b--;
                if (init_b == 0) foreach (mem_b[i]) mem_b[i] = '0;
            end else begin
                if (we && wa < DEPTH_B) mem_b[wa] = di;
                else if (we) err_b = 1'b1;
                if (re && ra >= DEPTH_B) err_b = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic r, input logic [6:0] ar, input logic o,
                         input logic w, input logic [6:0] aw, input logic [DW-1:0] d);
        @(negedge clk);
        commit();
        reset_ = rst; re = r; ra = ar; ore = o; we = w; wa = aw; di = d;
        pwr = $urandom;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [DW-1:0] d);
        drive(1'b1, 1'b0, 7'd0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rdq(input logic [6:0] a);
        drive(1'b1, 1'b1, a, 1'b1, 1'b0, 7'd0, '0);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom), 7'($urandom), 1'b1, 1'($urandom), 7'($urandom), rand_word());
            checks++;
            if ({dout_a, dout_vld_a, init_done_a, acc_err_a} !== '0) begin
                errors++;
                $display("FAIL reset_a: dout=%h vld=%b done=%b err=%b, want all 0",
                         dout_a, dout_vld_a, init_done_a, acc_err_a);
            end
            checks++;
            if ({dout_vld_b, init_done_b, acc_err_b} !== 3'b000) begin
                errors++;
                $display("FAIL reset_b: vld=%b done=%b err=%b, want 0 0 0",
                         dout_vld_b, init_done_b, acc_err_b);
            end
        end
    endtask

    task automatic wait_init(input int limit_a, input bit check_all);
        idle();
        for (int k = 0; k <= limit_a; k++) begin
            if (k > 0) idle();
            if (check_all || k == DEPTH_A - 1 || k == DEPTH_A) begin
                checks++;
                if (init_done_a !== (k >= DEPTH_A)) begin
                    errors++;
                    $display("FAIL init_done_a k=%0d: got %b want %b", k, init_done_a, k >= DEPTH_A);
                end
                checks++;
                if (init_done_b !== (k >= DEPTH_B)) begin
                    errors++;
                    $display("FAIL init_done_b k=%0d: got %b want %b", k, init_done_b, k >= DEPTH_B);
                end
            end
        end
    endtask

    task automatic check_err(input string tag);
        checks++;
        if (acc_err_a !== err_a) begin
            errors++;
            $display("FAIL %s acc_err_a: got %b want %b", tag, acc_err_a, err_a);
        end
        checks++;
        if (acc_err_b !== err_b) begin
            errors++;
            $display("FAIL %s acc_err_b: got %b want %b", tag, acc_err_b, err_b);
        end
    endtask

    task automatic test_reset();
        reset_cycles(3);
    endtask

    task automatic test_init();
        logic [DW-1:0] exp_b;
        wait_init(DEPTH_A, 1'b1);
        for (int i = 0; i < DEPTH_A + 2; i++) begin
            drive(1'b1, i < DEPTH_A, 7'(i), 1'b1, 1'b0, 7'd0, '0);
            if (i >= 2) begin
                checks++;
                if ({dout_vld_a, dout_a} !== {1'b1, mem_a[i-2]}) begin
                    errors++;
                    $display("FAIL init_read_a addr=%0d: vld=%b dout=%h want 1 %h",
                             i - 2, dout_vld_a, dout_a, mem_a[i-2]);
                end
            end
            if (i >= 1 && i <= DEPTH_A) begin
                exp_b = (i - 1 < DEPTH_B) ? mem_b[i-1] : '0;
                checks++;
                if ({dout_vld_b, dout_b} !== {1'b1, exp_b}) begin
                    errors++;
                    $display("FAIL init_read_b addr=%0d: vld=%b dout=%h want 1 %h",
                             i - 1, dout_vld_b, dout_b, exp_b);
                end
            end
        end
        check_err("oob_read");
    endtask

    task automatic test_write_read();
        logic [6:0]    a;
        logic [DW-1:0] d;
        for (int n = 0; n < 8; n++) begin
            a = (n == 0) ? 7'd5 : 7'($urandom_range(0, DEPTH_B - 1));
            d = (n == 0) ? 129'h1_DEAD : rand_word();
            wr(a, d);
            rdq(a);
            idle();
            checks++;
            if ({dout_vld_b, dout_b} !== {1'b1, mem_b[a]} || dout_vld_a !== 1'b0) begin
                errors++;
                $display("FAIL lat_n1 addr=%0d: b=%b/%h want 1/%h, a_vld=%b want 0",
                         a, dout_vld_b, dout_b, mem_b[a], dout_vld_a);
            end
            idle();
            checks++;
            if ({dout_vld_a, dout_a} !== {1'b1, mem_a[a]}) begin
                errors++;
                $display("FAIL lat_n2_a addr=%0d: %b/%h want 1/%h", a, dout_vld_a, dout_a, mem_a[a]);
            end
        end
    endtask

    task automatic test_forward();
        logic [6:0]    a;
        logic [DW-1:0] old_w, new_w;
        for (int n = 0; n < 4; n++) begin
            a     = (n == 0) ? 7'd9 : 7'($urandom_range(0, DEPTH_B - 1));
            old_w = rand_word();
            new_w = (n == 0) ? 129'hAB : rand_word();
            wr(a, old_w);
            rdq(a);
            wr(a, new_w);
            checks++;
            if ({dout_vld_b, dout_b} !== {1'b1, old_w}) begin
                errors++;
                $display("FAIL fwd_off_b addr=%0d: %b/%h want 1/%h", a, dout_vld_b, dout_b, old_w);
            end
            idle();
            checks++;
            if ({dout_vld_a, dout_a} !== {1'b1, new_w}) begin
                errors++;
                $display("FAIL fwd_on_a addr=%0d: %b/%h want 1/%h", a, dout_vld_a, dout_a, new_w);
            end
            new_w = rand_word();
            drive(1'b1, 1'b1, a, 1'b1, 1'b1, a, new_w);
            idle();
            checks++;
            if ({dout_vld_b, dout_b} !== {1'b1, new_w}) begin
                errors++;
                $display("FAIL same_cyc_b addr=%0d: %b/%h want 1/%h", a, dout_vld_b, dout_b, new_w);
            end
            idle();
            checks++;
            if ({dout_vld_a, dout_a} !== {1'b1, new_w}) begin
                errors++;
                $display("FAIL same_cyc_a addr=%0d: %b/%h want 1/%h", a, dout_vld_a, dout_a, new_w);
            end
        end
    endtask

    task automatic test_ore_hold();
        wr(7'd3, rand_word());
        wr(7'd4, rand_word());
        rdq(7'd3);
        rdq(7'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 7'd0, i == 2, 1'b0, 7'd0, '0);
            checks++;
            if ({dout_vld_a, dout_a} !== {1'b1, mem_a[3]}) begin
                errors++;
                $display("FAIL ore_hold i=%0d: %b/%h want 1/%h", i, dout_vld_a, dout_a, mem_a[3]);
            end
        end
        idle();
        checks++;
        if ({dout_vld_a, dout_a} !== {1'b0, mem_a[4]}) begin
            errors++;
            $display("FAIL ore_rise: %b/%h want 0/%h", dout_vld_a, dout_a, mem_a[4]);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) wr(7'(20 + j), rand_word());
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i < 8, 7'(20 + i), 1'b1, 1'b0, 7'd0, '0);
            if (i >= 2) begin
                checks++;
                if ({dout_vld_a, dout_a} !== {1'b1, mem_a[20+i-2]}) begin
                    errors++;
                    $display("FAIL b2b_a addr=%0d: %b/%h want 1/%h",
                             20 + i - 2, dout_vld_a, dout_a, mem_a[20+i-2]);
                end
            end
            if (i >= 1 && i <= 8) begin
                checks++;
                if ({dout_vld_b, dout_b} !== {1'b1, mem_b[20+i-1]}) begin
                    errors++;
                    $display("FAIL b2b_b addr=%0d: %b/%h want 1/%h",
                             20 + i - 1, dout_vld_b, dout_b, mem_b[20+i-1]);
                end
            end
        end
    endtask

    task automatic test_init_err();
        reset_cycles(2);
        idle();
        for (int k = 1; k <= DEPTH_A + 1; k++) begin
            if (k == 10) wr(7'd7, rand_word());
            else idle();
        end
        check_err("init_we");
        rdq(7'd7);
        idle();
        checks++;
        if ({dout_vld_b, dout_b} !== {1'b1, mem_b[7]}) begin
            errors++;
            $display("FAIL init_lost_b: %b/%h want 1/%h", dout_vld_b, dout_b, mem_b[7]);
        end
        idle();
        checks++;
        if ({dout_vld_a, dout_a} !== {1'b1, mem_a[7]}) begin
            errors++;
            $display("FAIL init_lost_a: %b/%h want 1/%h", dout_vld_a, dout_a, mem_a[7]);
        end
    endtask

    task automatic test_mid_reset();
        wr(7'd30, rand_word());
        rdq(7'd30);
        idle();
        idle();
        reset_cycles(2);
        idle();
        for (int k = 1; k < 50; k++) idle();
        reset_cycles(3);
        wait_init(DEPTH_A, 1'b0);
        check_err("after_reset");
    endtask

    task automatic test_errors();
        wr(7'd110, rand_word());
        idle();
        check_err("oob_write");
        rdq(7'd110);
        idle();
        checks++;
        if ({dout_vld_b, dout_b} !== {1'b1, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL oob_read_b: %b/%h want 1/0", dout_vld_b, dout_b);
        end
        idle();
        checks++;
        if ({dout_vld_a, dout_a} !== {1'b1, mem_a[110]}) begin
            errors++;
            $display("FAIL inrange_110_a: %b/%h want 1/%h", dout_vld_a, dout_a, mem_a[110]);
        end
        check_err("oob_read");
    endtask

    initial begin
        reset_ = 1'b0; re = 1'b0; ore = 1'b0; we = 1'b0;
        ra = '0; wa = '0; di = '0; pwr = '0;
        init_a = DEPTH_A; init_b = DEPTH_B; err_a = 1'b0; err_b = 1'b0;
        test_reset();
        test_init();
        test_write_read();
        test_forward();
        test_ore_hold();
        test_back_to_back();
        test_init_err();
        test_mid_reset();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
